// File: rtl/rotabit_if.sv
// Command channel into the rotating-bit sequencer: single-word commands over valid/ready.
interface rotabit_if #(
    parameter int unsigned DATA_W = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [DATA_W-1:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/rotabit_ctrl.sv
// Command-driven sequencer for a rotating-bit pattern: free-running rotation,
// counted bursts with a completion pulse, and an immediate stop.
module rotabit_ctrl #(
    parameter int unsigned       WIDTH   = 16,
    parameter int unsigned       DIV_W   = 16,
    parameter logic [WIDTH-1:0]  PAT_RST = WIDTH'(16'h0001),
    parameter int unsigned       DIV_RST = 1
) (
    input  logic             clk,
    input  logic             rst,
    rotabit_if.slave         bus,
    output logic [WIDTH-1:0] x,
    output logic             step,
    output logic             busy,
    output logic             done
);

    localparam int unsigned REM_W = 8;

    localparam logic [2:0] OP_LOAD   = 3'd0;
    localparam logic [2:0] OP_SETDIV = 3'd1;
    localparam logic [2:0] OP_RUN    = 3'd2;
    localparam logic [2:0] OP_BURST  = 3'd3;
    localparam logic [2:0] OP_STOP   = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_x;
    logic [DIV_W-1:0]   r_div;
    logic [DIV_W-1:0]   r_cnt;
    logic [REM_W-1:0]   r_rem;
    logic               r_dir;
    logic               r_step;
    logic               r_done;
    logic               r_busy;

    state_t             w_state_nxt;
    logic [WIDTH-1:0]   w_x_nxt;
    logic [DIV_W-1:0]   w_div_nxt;
    logic [DIV_W-1:0]   w_cnt_nxt;
    logic [REM_W-1:0]   w_rem_nxt;
    logic               w_dir_nxt;
    logic               w_step_nxt;
    logic               w_done_nxt;

    logic               w_accept;
    logic               w_tick;
    logic [REM_W-1:0]   w_burst_n;

    // Only STOP can get through while a rotation is in progress.
    assign bus.cmd_ready = (r_state == ST_IDLE) | (bus.cmd_op == OP_STOP);
    assign w_accept      = bus.cmd_valid & bus.cmd_ready;
    assign w_tick        = (r_state != ST_IDLE) && (r_cnt == (r_div - DIV_W'(1)));
    assign w_burst_n     = REM_W'(bus.cmd_data[7:0]);

    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_div_nxt   = r_div;
        w_cnt_nxt   = r_cnt;
        w_rem_nxt   = r_rem;
        w_dir_nxt   = r_dir;
        w_step_nxt  = 1'b0;
        w_done_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (bus.cmd_op)
                        OP_LOAD:   w_x_nxt = WIDTH'(bus.cmd_data);
                        OP_SETDIV: w_div_nxt = (bus.cmd_data == '0) ? DIV_W'(1)
                                                                   : DIV_W'(bus.cmd_data);
                        OP_RUN: begin
                            w_dir_nxt   = bus.cmd_data[0];
                            w_cnt_nxt   = '0;
                            w_state_nxt = ST_RUN;
                        end
                        OP_BURST: begin
                            w_dir_nxt = bus.cmd_data[8];
                            w_cnt_nxt = '0;
                            if (w_burst_n != '0) begin
                                w_rem_nxt   = w_burst_n;
                                w_state_nxt = ST_BURST;
                            end else begin
                                w_done_nxt  = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            ST_RUN, ST_BURST: begin
                // A STOP landing on a tick suppresses that tick entirely.
                if (w_accept) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_rem_nxt   = '0;
                end else if (w_tick) begin
                    w_cnt_nxt  = '0;
                    w_step_nxt = 1'b1;
                    w_x_nxt    = r_dir ? {r_x[0], r_x[WIDTH-1:1]}
                                       : {r_x[WIDTH-2:0], r_x[WIDTH-1]};
                    if (r_state == ST_BURST) begin
                        w_rem_nxt = r_rem - REM_W'(1);
                        if (r_rem == REM_W'(1)) begin
                            w_done_nxt  = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt + DIV_W'(1);
                end
            end

            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_x     <= PAT_RST;
            r_div   <= DIV_W'(DIV_RST);
            r_cnt   <= '0;
            r_rem   <= '0;
            r_dir   <= 1'b0;
            r_step  <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_div   <= w_div_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rem   <= w_rem_nxt;
            r_dir   <= w_dir_nxt;
            r_step  <= w_step_nxt;
            r_done  <= w_done_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    assign x    = r_x;
    assign step = r_step;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_rotabit_ctrl.sv
// Directed bench for rotabit_ctrl with hand-computed expected patterns.
module tb_rotabit_ctrl;

    localparam logic [2:0] OP_LOAD   = 3'd0;
    localparam logic [2:0] OP_SETDIV = 3'd1;
    localparam logic [2:0] OP_RUN    = 3'd2;
    localparam logic [2:0] OP_BURST  = 3'd3;
    localparam logic [2:0] OP_STOP   = 3'd4;
    localparam logic [2:0] OP_NOP    = 3'd5;

    logic        clk;
    logic        rst;
    logic [15:0] x;
    logic        step;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    rotabit_if #(.DATA_W(16)) u_if ();

    rotabit_ctrl u_dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (u_if),
        .x    (x),
        .step (step),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a command and hold it until accepted; returns 1 ns after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [15:0] data);
        bit ok = 1'b0;
        u_if.cmd_valid = 1'b1;
        u_if.cmd_op    = op;
        u_if.cmd_data  = data;
        for (int i = 0; i < 50 && !ok; i++) begin
            ok = (u_if.cmd_ready === 1'b1);
            @(posedge clk);
            #1;
        end
        if (!ok) check_eq("issue_timeout", 32'd0, 32'd1);
        u_if.cmd_valid = 1'b0;
        u_if.cmd_op    = OP_NOP;
        u_if.cmd_data  = '0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] exp_x;
    logic [15:0] burst_exp [5];

    initial begin
        burst_exp[0] = 16'hF807;
        burst_exp[1] = 16'hFC03;
        burst_exp[2] = 16'hFE01;
        burst_exp[3] = 16'hFF00;
        burst_exp[4] = 16'h7F80;

        rst = 1'b0;
        u_if.cmd_valid = 1'b0;
        u_if.cmd_op    = OP_NOP;
        u_if.cmd_data  = '0;
        #12;
        check_eq("rst_x",    32'(x),    32'h0001);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_step", 32'(step), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        cycle();
        check_eq("idle_ready", 32'(u_if.cmd_ready), 32'd1);

        // NOP is accepted and changes nothing
        issue(OP_NOP, 16'hFFFF);
        check_eq("nop_x",    32'(x),    32'h0001);
        check_eq("nop_busy", 32'(busy), 32'd0);

        // Free-running left rotation at the reset step rate of one per cycle
        issue(OP_RUN, 16'h0000);
        check_eq("run_busy",  32'(busy), 32'd1);
        check_eq("run_x0",    32'(x),    32'h0001);
        check_eq("run_step0", 32'(step), 32'd0);
        exp_x = 16'h0001;
        for (int k = 1; k <= 16; k++) begin
            cycle();
            exp_x = {exp_x[14:0], exp_x[15]};
            check_eq($sformatf("run_x%0d", k), 32'(x), 32'(exp_x));
            check_eq($sformatf("run_step%0d", k), 32'(step), 32'd1);
        end
        check_eq("run_wrap", 32'(x), 32'h0001);

        // A LOAD held during RUN is stalled while rotation continues
        u_if.cmd_valid = 1'b1;
        u_if.cmd_op    = OP_LOAD;
        u_if.cmd_data  = 16'hA5A5;
        #1;
        check_eq("stall_ready", 32'(u_if.cmd_ready), 32'd0);
        for (int k = 0; k < 2; k++) begin
            cycle();
            exp_x = {exp_x[14:0], exp_x[15]};
            check_eq("stall_x",    32'(x),    32'(exp_x));
            check_eq("stall_busy", 32'(busy), 32'd1);
        end
        issue(OP_STOP, 16'h0000);
        check_eq("stop_x",    32'(x),    32'(exp_x));
        check_eq("stop_busy", 32'(busy), 32'd0);
        check_eq("stop_step", 32'(step), 32'd0);
        issue(OP_LOAD, 16'hA5A5);
        check_eq("load_after_stop", 32'(x),    32'hA5A5);
        check_eq("load_step",       32'(step), 32'd0);

        // Burst of 5 right rotations, one every 3 cycles
        issue(OP_LOAD, 16'hF00F);
        issue(OP_SETDIV, 16'd3);
        issue(OP_BURST, 16'h0105);
        check_eq("burst_busy0", 32'(busy), 32'd1);
        check_eq("burst_x0",    32'(x),    32'hF00F);
        for (int k = 0; k < 5; k++) begin
            cycle();
            check_eq("burst_gap_step", 32'(step), 32'd0);
            cycle();
            check_eq("burst_gap_step", 32'(step), 32'd0);
            cycle();
            check_eq($sformatf("burst_x%0d", k + 1), 32'(x), 32'(burst_exp[k]));
            check_eq("burst_step", 32'(step), 32'd1);
            check_eq($sformatf("burst_done%0d", k + 1), 32'(done), (k == 4) ? 32'd1 : 32'd0);
        end
        check_eq("burst_busy_end", 32'(busy), 32'd0);
        cycle();
        check_eq("burst_done_clr", 32'(done), 32'd0);
        check_eq("burst_x_hold",   32'(x),    32'h7F80);

        // BURST with N=0 completes without moving
        issue(OP_BURST, 16'h0100);
        check_eq("b0_done", 32'(done), 32'd1);
        check_eq("b0_busy", 32'(busy), 32'd0);
        check_eq("b0_step", 32'(step), 32'd0);
        check_eq("b0_x",    32'(x),    32'h7F80);
        cycle();
        check_eq("b0_done_clr", 32'(done), 32'd0);
        check_eq("b0_step2",    32'(step), 32'd0);

        // STOP accepted on the same edge as the first tick wins
        issue(OP_LOAD, 16'h0001);
        issue(OP_SETDIV, 16'd4);
        issue(OP_RUN, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check_eq("sc_pre_step", 32'(step), 32'd0);
        end
        issue(OP_STOP, 16'h0000);
        check_eq("sc_x",    32'(x),    32'h0001);
        check_eq("sc_busy", 32'(busy), 32'd0);
        check_eq("sc_step", 32'(step), 32'd0);
        check_eq("sc_done", 32'(done), 32'd0);

        // Asynchronous reset in the middle of a burst
        issue(OP_SETDIV, 16'd2);
        issue(OP_LOAD, 16'h00F0);
        issue(OP_BURST, 16'h0010);
        for (int k = 0; k < 5; k++) cycle();
        check_eq("ar_pre_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("ar_x",    32'(x),    32'h0001);
        check_eq("ar_busy", 32'(busy), 32'd0);
        check_eq("ar_step", 32'(step), 32'd0);
        check_eq("ar_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        cycle();

        // Divider back to 1: first rotation one cycle after accept
        issue(OP_RUN, 16'h0000);
        cycle();
        check_eq("ar_div_x",    32'(x),    32'h0002);
        check_eq("ar_div_step", 32'(step), 32'd1);
        issue(OP_STOP, 16'h0000);
        check_eq("ar_stop_x", 32'(x), 32'h0002);

        // SETDIV 0 behaves as a divider of 1
        issue(OP_SETDIV, 16'd5);
        issue(OP_SETDIV, 16'd0);
        issue(OP_RUN, 16'h0000);
        cycle();
        check_eq("div0_x1", 32'(x), 32'h0004);
        cycle();
        check_eq("div0_x2", 32'(x), 32'h0008);
        issue(OP_STOP, 16'h0000);
        check_eq("div0_stop_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
